// File: rtl/icebus_frame_receiver_if.sv
// Bundle of the UART line input and the decoded-command outputs of the
// iCEboard frame receiver. The host/line side is the master; the receiver is the slave.
interface icebus_frame_receiver_if;
  logic        rx_i;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic [7:0]  cmd_motor;
  logic [31:0] cmd_data;
  logic [15:0] frame_count;
  logic [15:0] error_count;
  logic        busy;

  modport master (
    output rx_i,
    input  cmd_valid, cmd_code, cmd_motor, cmd_data, frame_count, error_count, busy
  );

  modport slave (
    input  rx_i,
    output cmd_valid, cmd_code, cmd_motor, cmd_data, frame_count, error_count, busy
  );
endinterface

// File: rtl/icebus_frame_receiver.sv
// Board end of the host->board command link: 8N1 UART receiver feeding a
// framed-command parser (AA 55 CMD MOTOR PAYLOAD CRC8) with good/error counters.
module icebus_frame_receiver #(
  parameter int NUMBER_OF_MOTORS = 6,
  parameter int CLOCK_FREQ_HZ    = 50_000_000,
  parameter int BAUDRATE         = 115200,
  parameter int TIMEOUT_BITS     = 20
) (
  input  logic clk,
  input  logic reset,
  icebus_frame_receiver_if.slave bus
);
  localparam int          CLKS_PER_BIT = CLOCK_FREQ_HZ / BAUDRATE;
  localparam logic [15:0] HALF_LAST    = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
  localparam logic [8:0]  NUM_MOTORS   = 9'(NUMBER_OF_MOTORS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_HUNT_A, P_HUNT_5, P_CMD, P_MOTOR, P_PAYLOAD, P_CHECK} p_state_t;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // UART receiver state
  logic       sync1_q, sync2_q, rx_prev_q;
  rx_state_t  rx_state_q, rx_state_d;
  logic [15:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic       byte_valid_q, byte_valid_d;
  logic       frame_err_q, frame_err_d;

  // Parser state
  p_state_t    p_state_q, p_state_d;
  logic [7:0]  code_q, code_d;
  logic [7:0]  motor_q, motor_d;
  logic        motor_bad_q, motor_bad_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  crc_q, crc_d;
  logic [1:0]  pay_cnt_q, pay_cnt_d;
  logic [1:0]  pay_last_q, pay_last_d;
  logic [31:0] timeout_q, timeout_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  cmd_code_q, cmd_code_d;
  logic [7:0]  cmd_motor_q, cmd_motor_d;
  logic [31:0] cmd_data_q, cmd_data_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [15:0] error_count_q, error_count_d;
  logic        err_inc;

  always_comb begin
    rx_state_d   = rx_state_q;
    bit_cnt_d    = bit_cnt_q + 16'd1;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        bit_cnt_d = '0;
        if (rx_prev_q && !sync2_q) rx_state_d = RX_START;
      end
      RX_START: if (bit_cnt_q == HALF_LAST) begin
        bit_cnt_d  = '0;
        bit_idx_d  = '0;
        // Line back high at mid start bit: glitch, silently ignored.
        rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (bit_cnt_q == BIT_LAST) begin
        bit_cnt_d = '0;
        shreg_d   = {sync2_q, shreg_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (bit_cnt_q == BIT_LAST) begin
        bit_cnt_d    = '0;
        byte_valid_d = sync2_q;
        frame_err_d  = !sync2_q;
        rx_state_d   = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    p_state_d     = p_state_q;
    code_d        = code_q;
    motor_d       = motor_q;
    motor_bad_d   = motor_bad_q;
    data_d        = data_q;
    crc_d         = crc_q;
    pay_cnt_d     = pay_cnt_q;
    pay_last_d    = pay_last_q;
    cmd_valid_d   = 1'b0;
    cmd_code_d    = cmd_code_q;
    cmd_motor_d   = cmd_motor_q;
    cmd_data_d    = cmd_data_q;
    frame_count_d = frame_count_q;
    err_inc       = 1'b0;
    timeout_d     = (p_state_q == P_HUNT_A || byte_valid_q) ? 32'd0 : timeout_q + 32'd1;

    if (frame_err_q) begin
      err_inc   = 1'b1;
      p_state_d = P_HUNT_A;
    end else if (byte_valid_q) begin
      case (p_state_q)
        P_HUNT_A: if (shreg_q == 8'hAA) p_state_d = P_HUNT_5;
        P_HUNT_5: begin
          crc_d = 8'h00;
          if (shreg_q == 8'h55)      p_state_d = P_CMD;
          else if (shreg_q != 8'hAA) p_state_d = P_HUNT_A;
        end
        P_CMD: begin
          code_d = shreg_q;
          crc_d  = crc8_byte(crc_q, shreg_q);
          data_d = '0;
          case (shreg_q)
            8'h01, 8'h03: begin pay_last_d = 2'd3; p_state_d = P_MOTOR; end
            8'h02:        begin pay_last_d = 2'd0; p_state_d = P_MOTOR; end
            default:      begin err_inc = 1'b1;    p_state_d = P_HUNT_A; end
          endcase
        end
        P_MOTOR: begin
          motor_d     = shreg_q;
          motor_bad_d = {1'b0, shreg_q} >= NUM_MOTORS;
          crc_d       = crc8_byte(crc_q, shreg_q);
          pay_cnt_d   = 2'd0;
          p_state_d   = P_PAYLOAD;
        end
        P_PAYLOAD: begin
          case (pay_cnt_q)
            2'd0:    data_d[7:0]   = shreg_q;
            2'd1:    data_d[15:8]  = shreg_q;
            2'd2:    data_d[23:16] = shreg_q;
            default: data_d[31:24] = shreg_q;
          endcase
          crc_d     = crc8_byte(crc_q, shreg_q);
          pay_cnt_d = pay_cnt_q + 2'd1;
          if (pay_cnt_q == pay_last_q) p_state_d = P_CHECK;
        end
        P_CHECK: begin
          if (shreg_q == crc_q && !motor_bad_q) begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = code_q;
            cmd_motor_d = motor_q;
            cmd_data_d  = data_q;
            if (frame_count_q != 16'hFFFF) frame_count_d = frame_count_q + 16'd1;
          end else begin
            err_inc = 1'b1;
          end
          p_state_d = P_HUNT_A;
        end
        default: p_state_d = P_HUNT_A;
      endcase
    end else if (p_state_q != P_HUNT_A && timeout_q == TIMEOUT_LAST) begin
      err_inc   = 1'b1;
      p_state_d = P_HUNT_A;
    end

    error_count_d = (err_inc && error_count_q != 16'hFFFF) ? error_count_q + 16'd1 : error_count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      rx_prev_q     <= 1'b1;
      rx_state_q    <= RX_IDLE;
      bit_cnt_q     <= '0;
      bit_idx_q     <= '0;
      shreg_q       <= '0;
      byte_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      p_state_q     <= P_HUNT_A;
      code_q        <= '0;
      motor_q       <= '0;
      motor_bad_q   <= 1'b0;
      data_q        <= '0;
      crc_q         <= '0;
      pay_cnt_q     <= '0;
      pay_last_q    <= '0;
      timeout_q     <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_code_q    <= '0;
      cmd_motor_q   <= '0;
      cmd_data_q    <= '0;
      frame_count_q <= '0;
      error_count_q <= '0;
    end else begin
      sync1_q       <= bus.rx_i;
      sync2_q       <= sync1_q;
      rx_prev_q     <= sync2_q;
      rx_state_q    <= rx_state_d;
      bit_cnt_q     <= bit_cnt_d;
      bit_idx_q     <= bit_idx_d;
      shreg_q       <= shreg_d;
      byte_valid_q  <= byte_valid_d;
      frame_err_q   <= frame_err_d;
      p_state_q     <= p_state_d;
      code_q        <= code_d;
      motor_q       <= motor_d;
      motor_bad_q   <= motor_bad_d;
      data_q        <= data_d;
      crc_q         <= crc_d;
      pay_cnt_q     <= pay_cnt_d;
      pay_last_q    <= pay_last_d;
      timeout_q     <= timeout_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_code_q    <= cmd_code_d;
      cmd_motor_q   <= cmd_motor_d;
      cmd_data_q    <= cmd_data_d;
      frame_count_q <= frame_count_d;
      error_count_q <= error_count_d;
    end
  end

  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_code    = cmd_code_q;
  assign bus.cmd_motor   = cmd_motor_q;
  assign bus.cmd_data    = cmd_data_q;
  assign bus.frame_count = frame_count_q;
  assign bus.error_count = error_count_q;
  assign bus.busy        = (p_state_q != P_HUNT_A);
endmodule

// File: tb/tb_icebus_frame_receiver.sv
// Directed plus randomized frames driven onto the UART line; expectations come
// from a frame-level model (augmented-message CRC division, counters, command list).
module tb_icebus_frame_receiver;
  localparam int CPB = 8;  // 800 kHz / 100 kBd

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [7:0]  code;
    logic [7:0]  motor;
    logic [31:0] data;
  } cmd_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   exp_err = 0;
  int   exp_frm = 0;
  cmd_t obs_q[$];

  icebus_frame_receiver_if bus();

  icebus_frame_receiver #(
    .NUMBER_OF_MOTORS(6),
    .CLOCK_FREQ_HZ(800_000),
    .BAUDRATE(100_000),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.cmd_valid === 1'b1) obs_q.push_back('{bus.cmd_code, bus.cmd_motor, bus.cmd_data});
  end

  // CRC as remainder of (message * x^8) mod x^8+x^2+x+1, bit by bit.
  function automatic logic [7:0] ref_crc(input bq_t msg);
    logic [7:0] r;
    logic       b, top;
    r = 8'h00;
    for (int k = 0; k < msg.size() * 8 + 8; k++) begin
      b   = (k < msg.size() * 8) ? msg[k / 8][7 - (k % 8)] : 1'b0;
      top = r[7];
      r   = {r[6:0], b};
      if (top) r = r ^ 8'h07;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_data(input bq_t pay);
    logic [31:0] d;
    d = 32'd0;
    for (int i = 0; i < pay.size(); i++) d = d | (32'(pay[i]) << (8 * i));
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_bits(input int n);
    bus.rx_i = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bus.rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rx_i = stop_bit;
    repeat (CPB) @(negedge clk);
    bus.rx_i = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic [7:0] motor,
                            input bq_t pay, input logic [7:0] crc_xor);
    bq_t msg;
    msg = {code, motor};
    foreach (pay[i]) msg.push_back(pay[i]);
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
    foreach (msg[i]) send_byte(msg[i], 1'b1);
    send_byte(ref_crc(msg) ^ crc_xor, 1'b1);
  endtask

  task automatic check_cmd(input string tag, input logic [7:0] code, input logic [7:0] motor,
                           input logic [31:0] data);
    cmd_t c;
    chk({tag, " pulses"}, 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0) c = obs_q.pop_front();
    else c = 'x;
    chk({tag, " code"}, 32'(c.code), 32'(code));
    chk({tag, " motor"}, 32'(c.motor), 32'(motor));
    chk({tag, " data"}, c.data, data);
    obs_q.delete();
  endtask

  task automatic check_counts(input string tag);
    chk({tag, " frame_count"}, 32'(bus.frame_count), 32'(exp_frm));
    chk({tag, " error_count"}, 32'(bus.error_count), 32'(exp_err));
  endtask

  initial begin
    bq_t pay;
    logic [7:0] code, motor, xr;
    bit good;

    bus.rx_i = 1'b1;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset cmd_valid", 32'(bus.cmd_valid), 32'd0);
    chk("reset cmd_code", 32'(bus.cmd_code), 32'd0);
    chk("reset cmd_motor", 32'(bus.cmd_motor), 32'd0);
    chk("reset cmd_data", bus.cmd_data, 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    check_counts("reset");
    reset = 1'b0;
    idle_bits(2);

    pay = {8'h78, 8'h56, 8'h34, 8'h12};
    send_frame(8'h01, 8'h02, pay, 8'h00);
    idle_bits(2);
    exp_frm++;
    check_cmd("setpoint", 8'h01, 8'h02, 32'h1234_5678);
    check_counts("setpoint");

    pay = {8'h03};
    send_frame(8'h02, 8'h05, pay, 8'h00);
    idle_bits(2);
    exp_frm++;
    check_cmd("ctrl_mode", 8'h02, 8'h05, 32'h0000_0003);
    send_frame(8'h02, 8'h06, pay, 8'h00);
    idle_bits(2);
    exp_err++;
    chk("bad_motor pulses", 32'(obs_q.size()), 32'd0);
    chk("bad_motor held data", bus.cmd_data, 32'h0000_0003);
    check_counts("bad_motor");

    // Corrupt CRC immediately followed by a good frame, no idle in between.
    pay = {8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(8'h03, 8'h01, pay, 8'h01);
    pay = {8'hA5, 8'h5A, 8'hAA, 8'h55};
    send_frame(8'h01, 8'h04, pay, 8'h00);
    idle_bits(2);
    exp_err++;
    exp_frm++;
    check_cmd("after_bad_crc", 8'h01, 8'h04, 32'h55AA_5AA5);
    check_counts("bad_crc");

    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b0);
    idle_bits(2);
    exp_err++;
    chk("framing busy", 32'(bus.busy), 32'd0);
    check_counts("framing");
    bus.rx_i = 1'b0;
    repeat (3) @(negedge clk);
    idle_bits(3);
    chk("glitch busy", 32'(bus.busy), 32'd0);
    chk("glitch pulses", 32'(obs_q.size()), 32'd0);
    check_counts("glitch");

    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h01, 1'b1);
    idle_bits(5);
    chk("stall busy early", 32'(bus.busy), 32'd1);
    idle_bits(20);
    exp_err++;
    chk("stall busy late", 32'(bus.busy), 32'd0);
    check_counts("timeout");
    send_byte(8'hAA, 1'b1);
    pay = {8'hE8, 8'h03, 8'h00, 8'h00};
    send_frame(8'h03, 8'h00, pay, 8'h00);
    idle_bits(2);
    exp_frm++;
    check_cmd("status_rate", 8'h03, 8'h00, 32'd1000);
    check_counts("status_rate");

    // Reset in the middle of the second payload byte.
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h11, 1'b1);
    bus.rx_i = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    reset = 1'b1;
    bus.rx_i = 1'b1;
    @(negedge clk);
    chk("midreset cmd_valid", 32'(bus.cmd_valid), 32'd0);
    chk("midreset cmd_code", 32'(bus.cmd_code), 32'd0);
    chk("midreset cmd_data", bus.cmd_data, 32'd0);
    chk("midreset busy", 32'(bus.busy), 32'd0);
    exp_frm = 0;
    exp_err = 0;
    check_counts("midreset");
    reset = 1'b0;
    @(negedge clk);
    chk("postreset cmd_valid", 32'(bus.cmd_valid), 32'd0);
    obs_q.delete();
    idle_bits(2);
    pay = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    send_frame(8'h01, 8'h03, pay, 8'h00);
    idle_bits(2);
    exp_frm++;
    check_cmd("after_reset", 8'h01, 8'h03, 32'hAABB_CCDD);
    check_counts("after_reset");

    for (int f = 0; f < 24; f++) begin
      if ($urandom_range(0, 9) == 0) begin
        code = 8'(8'h04 + $urandom_range(0, 63));
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(code, 1'b1);
        exp_err++;
        good = 1'b0;
      end else begin
        code  = 8'($urandom_range(1, 3));
        motor = 8'($urandom_range(0, 7));
        xr    = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        pay.delete();
        for (int i = 0; i < ((code == 8'h02) ? 1 : 4); i++) pay.push_back(8'($urandom()));
        send_frame(code, motor, pay, xr);
        good = (xr == 8'h00) && (motor < 8'd6);
        if (good) exp_frm++;
        else exp_err++;
      end
      idle_bits(2 + $urandom_range(0, 1));
      if (good) check_cmd($sformatf("rand%0d", f), code, motor, ref_data(pay));
      else chk($sformatf("rand%0d no pulse", f), 32'(obs_q.size()), 32'd0);
      obs_q.delete();
      check_counts($sformatf("rand%0d", f));
    end

    // Preload the error counter near full scale and check it saturates.
    force dut.error_count_q = 16'hFFFD;
    @(negedge clk);
    release dut.error_count_q;
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hAA, 1'b1);
      send_byte(8'h55, 1'b1);
      send_byte(8'h7E, 1'b1);
      idle_bits(2);
      chk($sformatf("saturate%0d", i), 32'(bus.error_count), (i == 0) ? 32'hFFFE : 32'hFFFF);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
